instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the single-cycle MIPS datapath. It sits directly upstream of the control unit and feeds the decode fields (op, func, rs, rt, rd, imm) to it.
- Holds the PC and issues requests to instruction memory over a req/ack handshake.
- Latches the returned word into an instruction register and presents it to decode with a valid/ready handshake.
- Computes the next PC: sequential, branch or jump.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction memory request
- imem_addr  out  32  fetch address; equals pc
- imem_ack  in  1  memory accepted request; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- ir_ready  in  1  downstream consumes current instruction this cycle
- branch_taken  in  1  Branch & ALU zero for the instruction being consumed
- instr_valid  out  1  ir holds a valid instruction
- instr  out  32  instruction register
- op  out  6  instr[31:26]
- func  out  6  instr[5:0]
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11]
- imm  out  16  instr[15:0]
- pc_out  out  32  address of the instruction in instr
- pc_plus4  out  32  pc_out + 4
- instr_count  out  32  number of instructions consumed; wraps modulo 2^32

## Operation
- FSM has two states, REQ and HOLD. It enters REQ on reset.
- REQ:
  - imem_req=1, instr_valid=0.
  - On imem_ack: instr <= imem_rdata, pc_out <= pc, next state HOLD.
  - Without ack: stay in REQ, with imem_addr held stable.
- HOLD:
  - imem_req=0, instr_valid=1; instr and all decode fields are held stable.
  - On ir_ready: update pc, increment instr_count, next state REQ.
  - Without ir_ready: stay in HOLD indefinitely.
- Next-PC selection on consume (priority order):
  1. op==6'b000010 (j): pc <= {pc_plus4[31:28], instr[25:0], 2'b00}.
  2. branch_taken=1: pc <= pc_plus4 + {{14{imm[15]}}, imm, 2'b00}.
  3. Otherwise: pc <= pc_plus4.
- All PC arithmetic is 32-bit and wraps modulo 2^32 (e.g. pc 32'hFFFF_FFFC + 4 = 0).
- branch_taken, ir_ready and imem_rdata are ignored in any state other than the one that samples them.
- imem_ack while imem_req=0 is ignored.
- Decode fields are pure slices of instr. While instr_valid=0 they show the last latched instruction (0 after reset).

## Timing
- Reset values:
  - state=REQ, pc=RESET_PC, imem_addr=RESET_PC.
  - instr=0, pc_out=RESET_PC, pc_plus4=RESET_PC+4.
  - instr_valid=0, instr_count=0.
  - imem_req=0 while rst_n=0; it rises in the first cycle after rst_n deasserts.
- imem_req and instr_valid are registered outputs, decoded from state only.
- Minimum throughput is 2 cycles per instruction: ack in cycle N, instr_valid in cycle N+1, consume in N+1, next imem_req in N+2.
- Handshake rules:
  - Downstream may hold ir_ready high continuously.
  - Each ack is consumed exactly once, and each HOLD is consumed exactly once.
- Reset asserted mid-operation, in either state, returns immediately (asynchronously) to the reset values. A pending memory response is discarded.

## Test plan
- Reset and first fetch: rst_n low, then high; ack after 3 wait cycles with 32'h2009_0005 -> imem_addr=0 throughout the wait; then instr_valid=1, op=6'h08, rt=9, imm=5, pc_out=0.
- Sequential stream: ack every cycle, ir_ready=1, branch_taken=0, 4 instructions -> addresses 0, 4, 8, 12; instr_valid asserted every other cycle; instr_count=4.
- Backpressure: ir_ready held low 5 cycles in HOLD -> instr/pc_out unchanged, imem_req=0, instr_count unchanged; consumed on the first ir_ready=1.
- Branch: instr 32'h1000_FFFE (beq, imm=-2) at pc 32'h10, branch_taken=1 -> next imem_addr=32'h0C. Same with branch_taken=0 -> 32'h14.
- Jump: instr 32'h0800_0040 at pc 32'h4000_0000 -> next imem_addr=32'h4000_0100, regardless of branch_taken.
- Mid-fetch reset and wrap: rst_n pulsed low while in REQ awaiting ack -> all outputs at reset values, late ack ignored. Separately, RESET_PC=32'hFFFF_FFFC with a sequential consume -> next imem_addr=0.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage for the single-cycle MIPS datapath.
// Holds the PC, fetches over a req/ack handshake, latches the returned word
// into the instruction register and hands it to decode over valid/ready.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        ir_ready,
  input  logic        branch_taken,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_count
);

  typedef enum logic {
    REQ  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [5:0] OP_J = 6'b000010;

  state_t      state_q, state_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] count_q, count_d;
  logic [31:0] seq_pc;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  assign seq_pc = pc_out_q + 32'd4;

  // Next-PC selection for the instruction being consumed: jump beats branch beats sequential.
  always_comb begin
    branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    next_pc    = seq_pc;
    if (instr_q[31:26] == OP_J) begin
      next_pc = {seq_pc[31:28], instr_q[25:0], 2'b00};
    end else if (branch_taken) begin
      next_pc = seq_pc + branch_off;
    end
  end

  // Fetch FSM: REQ waits for a memory ack (only honoured while the request is
  // actually driven), HOLD presents the word until downstream consumes it.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    count_d   = count_q;
    case (state_q)
      REQ: begin
        if (imem_req_q && imem_ack) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (ir_ready) begin
          pc_d    = next_pc;
          count_d = count_q + 32'd1;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
    imem_req_d    = (state_d == REQ);
    instr_valid_d = (state_d == HOLD);
  end

  // State and datapath registers; request stays low during reset and rises on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= REQ;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      pc_out_q      <= RESET_PC;
      count_q       <= 32'd0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      count_q       <= count_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign rs          = instr_q[25:21];
  assign rt          = instr_q[20:16];
  assign rd          = instr_q[15:11];
  assign imm         = instr_q[15:0];
  assign func        = instr_q[5:0];
  assign pc_out      = pc_out_q;
  assign pc_plus4    = seq_pc;
  assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: three instances with different reset PCs share
// the same stimulus, since the handshake timing does not depend on the PC.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ir_ready;
  logic        branch_taken;

  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc_out, pc_plus4, instr_count;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc_out, w_pc_plus4, w_count;
  logic [5:0]  w_op, w_func;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_imm;

  logic        j_req, j_valid;
  logic [31:0] j_addr, j_instr, j_pc_out, j_pc_plus4, j_count;
  logic [5:0]  j_op, j_func;
  logic [4:0]  j_rs, j_rt, j_rd;
  logic [15:0] j_imm;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_count;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir_ready(ir_ready),
    .branch_taken(branch_taken), .instr_valid(instr_valid), .instr(instr),
    .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .instr_count(instr_count)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir_ready(ir_ready),
    .branch_taken(branch_taken), .instr_valid(w_valid), .instr(w_instr),
    .op(w_op), .func(w_func), .rs(w_rs), .rt(w_rt), .rd(w_rd), .imm(w_imm),
    .pc_out(w_pc_out), .pc_plus4(w_pc_plus4), .instr_count(w_count)
  );

  instr_fetch #(.RESET_PC(32'h4000_0000)) dut_j (
    .clk(clk), .rst_n(rst_n), .imem_req(j_req), .imem_addr(j_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir_ready(ir_ready),
    .branch_taken(branch_taken), .instr_valid(j_valid), .instr(j_instr),
    .op(j_op), .func(j_func), .rs(j_rs), .rt(j_rt), .rd(j_rd), .imm(j_imm),
    .pc_out(j_pc_out), .pc_plus4(j_pc_plus4), .instr_count(j_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference next-PC rule, written straight from the MIPS definitions.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                             input bit taken);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    off = int'($signed(w[15:0])) * 4;
    if (w[31:26] == 6'd2) return {seq[31:28], w[25:0], 2'b00};
    if (taken) return seq + 32'(off);
    return seq;
  endfunction

  // Reset all instances and leave the bench at the first negedge with imem_req high.
  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0;
    ir_ready = 1'b0;
    branch_taken = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Memory side: wait (bounded) for a request, stall for some cycles, then return a word.
  task automatic serve(input logic [31:0] w, input int waits);
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL serve_timeout imem_req got %b want 1", imem_req);
    end
    repeat (waits) @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = w;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
  endtask

  // Downstream side: consume the held instruction for one cycle.
  task automatic consume(input bit taken);
    ir_ready = 1'b1;
    branch_taken = taken;
    @(negedge clk);
    ir_ready = 1'b0;
    branch_taken = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    ir_ready = 1'b0;
    branch_taken = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({imem_req, instr_valid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_req_valid got %b want 00", {imem_req, instr_valid});
    end
    checks++;
    if ({imem_addr, instr, pc_out, pc_plus4, instr_count} !== {32'h0, 32'h0, 32'h0, 32'h4, 32'h0}) begin
      errors++;
      $display("[TB] FAIL reset_values addr %h instr %h pc_out %h pc4 %h cnt %h", imem_addr, instr,
               pc_out, pc_plus4, instr_count);
    end
    checks++;
    if ({w_addr, w_pc_out, w_pc_plus4} !== {32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0}) begin
      errors++;
      $display("[TB] FAIL reset_wrap_pc addr %h pc_out %h pc4 %h want fffffffc fffffffc 0", w_addr,
               w_pc_out, w_pc_plus4);
    end
  endtask

  task automatic test_first_fetch();
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL req_after_release got %b want 0", imem_req);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
        errors++;
        $display("[TB] FAIL first_wait req %b addr %h want 1 0", imem_req, imem_addr);
      end
      @(negedge clk);
    end
    imem_ack = 1'b1;
    imem_rdata = 32'h2009_0005;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if ({instr_valid, imem_req, op, rs, rt, imm} !== {1'b1, 1'b0, 6'h08, 5'd0, 5'd9, 16'd5}) begin
      errors++;
      $display("[TB] FAIL first_decode valid %b req %b op %h rs %0d rt %0d imm %h", instr_valid,
               imem_req, op, rs, rt, imm);
    end
    checks++;
    if ({pc_out, pc_plus4} !== {32'h0, 32'h4}) begin
      errors++;
      $display("[TB] FAIL first_pc pc_out %h pc4 %h want 0 4", pc_out, pc_plus4);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    imem_ack = 1'b1;
    ir_ready = 1'b1;
    branch_taken = 1'b0;
    for (int i = 0; i < 8; i++) begin
      imem_rdata = 32'h0000_0020 + 32'(i);
      checks++;
      if ({imem_req, instr_valid} !== {(i % 2 == 0), (i % 2 == 1)}) begin
        errors++;
        $display("[TB] FAIL seq_handshake cycle %0d req %b valid %b", i, imem_req, instr_valid);
      end
      if (i % 2 == 0) begin
        checks++;
        if (imem_addr !== 32'(4 * (i / 2))) begin
          errors++;
          $display("[TB] FAIL seq_addr got %h want %h", imem_addr, 32'(4 * (i / 2)));
        end
      end
      @(negedge clk);
    end
    imem_ack = 1'b0;
    ir_ready = 1'b0;
    checks++;
    if ({instr_count, imem_addr, imem_req} !== {32'd4, 32'h10, 1'b1}) begin
      errors++;
      $display("[TB] FAIL seq_end cnt %0d addr %h req %b want 4 10 1", instr_count, imem_addr, imem_req);
    end
  endtask

  task automatic test_branch();
    serve(32'h1000_FFFE, 0);
    checks++;
    if ({instr_valid, pc_out} !== {1'b1, 32'h10}) begin
      errors++;
      $display("[TB] FAIL beq_hold valid %b pc_out %h want 1 10", instr_valid, pc_out);
    end
    consume(1'b1);
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0C}) begin
      errors++;
      $display("[TB] FAIL beq_taken req %b addr %h want 1 0c", imem_req, imem_addr);
    end
    serve(32'h0000_0020, 1);
    consume(1'b0);
    serve(32'h1000_FFFE, 0);
    consume(1'b0);
    checks++;
    if ({imem_addr, instr_count} !== {32'h14, 32'd7}) begin
      errors++;
      $display("[TB] FAIL beq_not_taken addr %h cnt %0d want 14 7", imem_addr, instr_count);
    end
  endtask

  task automatic test_backpressure();
    serve(32'h8C22_0004, 2);
    for (int i = 0; i < 5; i++) begin
      imem_ack = 1'b1;
      imem_rdata = $urandom;
      branch_taken = 1'b1;
      checks++;
      if ({instr_valid, imem_req, instr, pc_out, instr_count} !==
          {1'b1, 1'b0, 32'h8C22_0004, 32'h14, 32'd7}) begin
        errors++;
        $display("[TB] FAIL backpressure valid %b req %b instr %h pc_out %h cnt %0d", instr_valid,
                 imem_req, instr, pc_out, instr_count);
      end
      @(negedge clk);
    end
    imem_ack = 1'b0;
    consume(1'b0);
    checks++;
    if ({imem_req, imem_addr, instr_count} !== {1'b1, 32'h18, 32'd8}) begin
      errors++;
      $display("[TB] FAIL bp_consume req %b addr %h cnt %0d want 1 18 8", imem_req, imem_addr,
               instr_count);
    end
  endtask

  task automatic test_jump();
    do_reset();
    serve(32'h0800_0040, 0);
    checks++;
    if (j_pc_out !== 32'h4000_0000) begin
      errors++;
      $display("[TB] FAIL jump_pc_out got %h want 40000000", j_pc_out);
    end
    consume(1'b1);
    checks++;
    if (j_addr !== 32'h4000_0100) begin
      errors++;
      $display("[TB] FAIL jump_target got %h want 40000100", j_addr);
    end
    checks++;
    if (imem_addr !== 32'h0000_0100) begin
      errors++;
      $display("[TB] FAIL jump_target_low got %h want 00000100", imem_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    serve(32'h0000_0020, 0);
    consume(1'b0);
    checks++;
    if ({w_req, w_addr, w_count} !== {1'b1, 32'h0, 32'd1}) begin
      errors++;
      $display("[TB] FAIL pc_wrap req %b addr %h cnt %0d want 1 0 1", w_req, w_addr, w_count);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    serve(32'h2129_0001, 0);
    consume(1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, instr_valid, imem_addr, instr, pc_out, pc_plus4, instr_count} !==
        {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0}) begin
      errors++;
      $display("[TB] FAIL mid_reset req %b valid %b addr %h instr %h pc_out %h pc4 %h cnt %0d",
               imem_req, instr_valid, imem_addr, instr, pc_out, pc_plus4, instr_count);
    end
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if ({instr_valid, imem_req, instr} !== {1'b0, 1'b1, 32'h0}) begin
      errors++;
      $display("[TB] FAIL late_ack valid %b req %b instr %h want 0 1 0", instr_valid, imem_req, instr);
    end
    @(negedge clk);
    checks++;
    if ({instr_valid, imem_addr} !== {1'b0, 32'h0}) begin
      errors++;
      $display("[TB] FAIL late_ack_after valid %b addr %h want 0 0", instr_valid, imem_addr);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    bit          taken;
    do_reset();
    exp_pc = 32'h0;
    exp_count = 32'h0;
    for (int k = 0; k < 40; k++) begin
      w = $urandom;
      serve(w, int'($urandom_range(0, 3)));
      checks++;
      if ({instr_valid, instr, pc_out, op, rd, func} !==
          {1'b1, w, exp_pc, w[31:26], w[15:11], w[5:0]}) begin
        errors++;
        $display("[TB] FAIL rand_hold valid %b instr %h want %h pc_out %h want %h", instr_valid,
                 instr, w, pc_out, exp_pc);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      taken = 1'($urandom_range(0, 1));
      consume(taken);
      exp_pc = model_next(exp_pc, w, taken);
      exp_count = exp_count + 32'd1;
      checks++;
      if ({imem_req, imem_addr, instr_count} !== {1'b1, exp_pc, exp_count}) begin
        errors++;
        $display("[TB] FAIL rand_next req %b addr %h want %h cnt %0d want %0d", imem_req, imem_addr,
                 exp_pc, instr_count, exp_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential();
    test_branch();
    test_backpressure();
    test_jump();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
